// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parameterised register file with a per-register pending
// scoreboard for RAW hazard detection, optional hardwired zero register,
// optional writeback-to-read bypass, and a sequential post-reset clear sweep.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   init_busy             clear sweep in progress (writes/issues/read data masked)
//   read_reg1/2           read indices
//   read_data1/2          combinational read data
//   pending1/2            read index has an outstanding producer
//   issue_valid/issue_reg mark issue_reg as pending
//   reg_write/write_reg/write_data  writeback port; also clears pending
//   pending_count         registered popcount of pending bits
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_busy,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              pending1,
  output logic              pending2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [ADDR_W:0]   pending_count
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  pending_q, pending_d;
  logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic              busy_q, busy_d;
  logic [ADDR_W:0]   pending_count_q, pending_count_d;

  logic              wr_legal, iss_legal;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0]             rpend;

  assign wr_legal  = reg_write && !busy_q && !((ZERO_REG != 0) && (write_reg == '0));
  assign iss_legal = issue_valid && !busy_q && !((ZERO_REG != 0) && (issue_reg == '0));

  // Sweep: one entry per edge; busy drops on the edge that clears the last entry.
  always_comb begin
    sweep_cnt_d = sweep_cnt_q;
    busy_d      = busy_q;
    if (busy_q) begin
      sweep_cnt_d = sweep_cnt_q + ADDR_W'(1);
      if (&sweep_cnt_q) busy_d = 1'b0;
    end
  end

  // Single storage write port shared by the sweep and writeback.
  // Reset itself never touches storage.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_reg;
    mem_wdata = write_data;
    if (!reset) begin
      if (busy_q) begin
        mem_we    = 1'b1;
        mem_waddr = sweep_cnt_q;
        mem_wdata = '0;
      end else if (wr_legal) begin
        mem_we = 1'b1;
      end
    end
  end

  // Issue is applied after writeback so a same-index issue wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_legal)  pending_d[write_reg] = 1'b0;
    if (iss_legal) pending_d[issue_reg] = 1'b1;
    pending_count_d = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      pending_count_d = pending_count_d + (ADDR_W + 1)'(pending_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q       <= '0;
      pending_count_q <= '0;
      sweep_cnt_q     <= '0;
      busy_q          <= 1'b1;
    end else begin
      pending_q       <= pending_d;
      pending_count_q <= pending_count_d;
      sweep_cnt_q     <= sweep_cnt_d;
      busy_q          <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign raddr = {read_reg2, read_reg1};

  always_comb begin
    rdata = '0;
    rpend = '0;
    for (int p = 0; p < 2; p++) begin
      rdata[p] = mem_q[raddr[p]];
      rpend[p] = pending_q[raddr[p]];
      if ((BYPASS != 0) && wr_legal && (write_reg == raddr[p])) begin
        rdata[p] = write_data;
        // A same-cycle issue to this index keeps it hazardous.
        if (!(iss_legal && (issue_reg == raddr[p]))) rpend[p] = 1'b0;
      end
      if (busy_q || ((ZERO_REG != 0) && (raddr[p] == '0))) begin
        rdata[p] = '0;
        rpend[p] = 1'b0;
      end
    end
  end

  assign read_data1    = rdata[0];
  assign read_data2    = rdata[1];
  assign pending1      = rpend[0];
  assign pending2      = rpend[1];
  assign init_busy     = busy_q;
  assign pending_count = pending_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypassing instance and a non-bypassing
// instance share stimulus. Expected values are pushed to a queue when stimulus
// is driven and popped as the DUT outputs are sampled.
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid, reg_write;
  logic [AW-1:0] issue_reg, write_reg, read_reg1, read_reg2;
  logic [DW-1:0] write_data;

  logic          busy, busy_nb;
  logic [DW-1:0] rd1, rd2, rd1_nb, rd2_nb;
  logic          p1, p2, p1_nb, p2_nb;
  logic [AW:0]   cnt, cnt_nb;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .init_busy(busy),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1), .read_data2(rd2), .pending1(p1), .pending2(p2),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .pending_count(cnt)
  );

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .init_busy(busy_nb),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_nb), .read_data2(rd2_nb), .pending1(p1_nb), .pending2(p2_nb),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .pending_count(cnt_nb)
  );

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic          iv;
    logic [AW-1:0] ir;
    logic          wv;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    logic [AW-1:0] r1, r2;
    logic [DW-1:0] e_rd1, e_rd2, e_rd1_nb;
    logic          e_p1, e_p2, e_p1_nb;
    logic [AW:0]   e_cnt;
  } vec_t;
  vec_t vecs[13];

  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(logic iv, logic [AW-1:0] ir, logic wv, logic [AW-1:0] wr,
                              logic [DW-1:0] wd, logic [AW-1:0] r1, logic [AW-1:0] r2,
                              logic [DW-1:0] e_rd1, logic [DW-1:0] e_rd2,
                              logic [DW-1:0] e_rd1_nb, logic e_p1, logic e_p2,
                              logic e_p1_nb, logic [AW:0] e_cnt);
    vec_t v;
    v.iv = iv; v.ir = ir; v.wv = wv; v.wr = wr; v.wd = wd; v.r1 = r1; v.r2 = r2;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_rd1_nb = e_rd1_nb;
    v.e_p1 = e_p1; v.e_p2 = e_p2; v.e_p1_nb = e_p1_nb; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic push(input string name, input logic [63:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [63:0] act);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got %0h with no expected value queued", act);
      return;
    end
    e = sb_q.pop_front();
    if (act !== e.val) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until init_busy falls; returns edge count, 0 if the bound expires.
  task automatic wait_sweep(output int edges);
    edges = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (!busy) begin
        edges = n;
        break;
      end
    end
    reg_write   = 1'b0;
    issue_valid = 1'b0;
  endtask

  int edges;

  initial begin
    reset = 1'b1; issue_valid = 1'b0; reg_write = 1'b0;
    issue_reg = '0; write_reg = '0; write_data = '0;
    read_reg1 = 5'd7; read_reg2 = 5'd0;

    //          iv ir     wv wr     wd            r1     r2     rd1           rd2           rd1_nb        p1 p2 p1nb cnt
    vecs[0]  = mk(0, 5'd0, 1, 5'd5, 32'h12345678, 5'd5, 5'd5, 32'h12345678, 32'h12345678, 32'h0,        0, 0, 0, 6'd0);
    vecs[1]  = mk(0, 5'd0, 0, 5'd0, 32'h0,        5'd5, 5'd0, 32'h12345678, 32'h0,        32'h12345678, 0, 0, 0, 6'd0);
    vecs[2]  = mk(1, 5'd0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0,        32'h12345678, 32'h0,        0, 0, 0, 6'd0);
    vecs[3]  = mk(0, 5'd0, 0, 5'd0, 32'h0,        5'd0, 5'd5, 32'h0,        32'h12345678, 32'h0,        0, 0, 0, 6'd0);
    vecs[4]  = mk(1, 5'd3, 0, 5'd0, 32'h0,        5'd3, 5'd4, 32'h0,        32'h0,        32'h0,        0, 0, 0, 6'd1);
    vecs[5]  = mk(1, 5'd4, 0, 5'd0, 32'h0,        5'd3, 5'd4, 32'h0,        32'h0,        32'h0,        1, 0, 1, 6'd2);
    vecs[6]  = mk(0, 5'd0, 1, 5'd3, 32'hA,        5'd3, 5'd4, 32'hA,        32'h0,        32'h0,        0, 1, 1, 6'd1);
    vecs[7]  = mk(0, 5'd0, 0, 5'd0, 32'h0,        5'd3, 5'd4, 32'hA,        32'h0,        32'hA,        0, 1, 0, 6'd1);
    vecs[8]  = mk(1, 5'd9, 0, 5'd0, 32'h0,        5'd9, 5'd4, 32'h0,        32'h0,        32'h0,        0, 1, 0, 6'd2);
    vecs[9]  = mk(1, 5'd9, 1, 5'd9, 32'h55,       5'd9, 5'd4, 32'h55,       32'h0,        32'h0,        1, 1, 1, 6'd2);
    vecs[10] = mk(0, 5'd0, 0, 5'd0, 32'h0,        5'd9, 5'd4, 32'h55,       32'h0,        32'h55,       1, 1, 1, 6'd2);
    vecs[11] = mk(0, 5'd0, 1, 5'd5, 32'h99,       5'd5, 5'd4, 32'h99,       32'h0,        32'h12345678, 0, 1, 0, 6'd2);
    vecs[12] = mk(1, 5'd4, 0, 5'd0, 32'h0,        5'd4, 5'd9, 32'h0,        32'h55,       32'h0,        1, 1, 1, 6'd2);

    // Reset state.
    step(); step();
    push("reset_busy", 64'd1);  check(64'(busy));
    push("reset_count", 64'd0); check(64'(cnt));

    // Sweep with a write and issue to $7 attempted throughout.
    reset = 1'b0; reg_write = 1'b1; write_reg = 5'd7; write_data = 32'hDEADBEEF;
    issue_valid = 1'b1; issue_reg = 5'd7;
    #1;
    push("busy_rd1_masked", 64'd0); check(64'(rd1));
    push("busy_p1_masked", 64'd0);  check(64'(p1));
    wait_sweep(edges);
    push("sweep_edges", 64'd32); check(64'(edges));
    #1;
    push("post_sweep_rd7", 64'd0);    check(64'(rd1));
    push("post_sweep_rd7_nb", 64'd0); check(64'(rd1_nb));
    push("post_sweep_count", 64'd0);  check(64'(cnt));
    push("post_sweep_p7", 64'd0);     check(64'(p1));

    for (int i = 0; i < 13; i++) begin
      issue_valid = vecs[i].iv; issue_reg = vecs[i].ir;
      reg_write = vecs[i].wv; write_reg = vecs[i].wr; write_data = vecs[i].wd;
      read_reg1 = vecs[i].r1; read_reg2 = vecs[i].r2;
      push($sformatf("v%0d_rd1", i), 64'(vecs[i].e_rd1));
      push($sformatf("v%0d_rd2", i), 64'(vecs[i].e_rd2));
      push($sformatf("v%0d_rd1_nb", i), 64'(vecs[i].e_rd1_nb));
      push($sformatf("v%0d_p1", i), 64'(vecs[i].e_p1));
      push($sformatf("v%0d_p2", i), 64'(vecs[i].e_p2));
      push($sformatf("v%0d_p1_nb", i), 64'(vecs[i].e_p1_nb));
      push($sformatf("v%0d_count", i), 64'(vecs[i].e_cnt));
      #1;
      check(64'(rd1)); check(64'(rd2)); check(64'(rd1_nb));
      check(64'(p1)); check(64'(p2)); check(64'(p1_nb));
      step();
      issue_valid = 1'b0; reg_write = 1'b0;
      check(64'(cnt));
    end

    // Reset with producers outstanding, then reset again at sweep entry 10
    // while an issue to $9 is held (ignored while busy).
    reset = 1'b1;
    step();
    reset = 1'b0; issue_valid = 1'b1; issue_reg = 5'd9;
    push("rst2_count", 64'd0); check(64'(cnt));
    push("rst2_busy", 64'd1);  check(64'(busy));
    for (int n = 0; n < 10; n++) step();
    push("mid_sweep_busy", 64'd1); check(64'(busy));
    reset = 1'b1;
    step();
    reset = 1'b0;
    push("mid_rst_count", 64'd0); check(64'(cnt));
    wait_sweep(edges);
    push("restart_edges", 64'd32); check(64'(edges));
    read_reg1 = 5'd9; read_reg2 = 5'd5;
    #1;
    push("final_rd9", 64'd0);   check(64'(rd1));
    push("final_rd5", 64'd0);   check(64'(rd2));
    push("final_p9", 64'd0);    check(64'(p1));
    push("final_count", 64'd0); check(64'(cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parameterised successor to the 32x32 register file. Configurable data width and depth, optional hardwired zero register, and optional write-to-read bypass.
- Adds a per-register pending scoreboard so decode can detect RAW hazards against in-flight producers.
- Adds a sequential post-reset clear sweep in place of a single-cycle parallel clear.
- Sits between decode (reads, issue) and writeback (write port) in the MIPS datapath.

Parameters:
DATA_W  32  register width in bits
ADDR_W  5  register index width; DEPTH = 2**ADDR_W entries
ZERO_REG  1  1: entry 0 reads 0; writes and issues to entry 0 are ignored
BYPASS  1  1: same-cycle writeback data and pending-clear are forwarded to read ports

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high
init_busy  out  1  clear sweep in progress; write, issue and read data are masked
read_reg1  in  ADDR_W  read port 1 index
read_reg2  in  ADDR_W  read port 2 index
read_data1  out  DATA_W  combinational read data, port 1
read_data2  out  DATA_W  combinational read data, port 2
pending1  out  1  read_reg1 has an outstanding producer
pending2  out  1  read_reg2 has an outstanding producer
issue_valid  in  1  instruction issued that will write issue_reg
issue_reg  in  ADDR_W  destination of the issued instruction
reg_write  in  1  writeback enable
write_reg  in  ADDR_W  writeback index
write_data  in  DATA_W  writeback data
pending_count  out  ADDR_W+1  number of set pending bits

Behaviour:
- Reset (sampled at rising edge while reset=1):
  - pending bits all 0; pending_count=0.
  - Sweep counter=0; init_busy=1.
  - Storage is not cleared by reset itself.
- Clear sweep:
  - Starts on each edge with reset=0 and init_busy=1: entry[counter] <= 0, then counter increments.
  - DEPTH edges clear entries 0..DEPTH-1. init_busy drops to 0 on the edge that clears entry DEPTH-1.
  - Reset asserted mid-sweep restarts the sweep from entry 0.
- While init_busy=1:
  - read_data1/2 = 0; pending1/2 = 0.
  - reg_write and issue_valid are ignored (no storage or scoreboard change).
- Reads:
  - Asynchronous. read_dataN = 0 if ZERO_REG and read_regN=0; otherwise entry[read_regN].
  - If BYPASS and reg_write and write_reg==read_regN and the write is legal: read_dataN = write_data in the same cycle.
  - If BYPASS=0, a written value is visible on the cycle after the write edge.
- Write:
  - On the edge, if reg_write, not busy, and not (ZERO_REG and write_reg=0): entry[write_reg] <= write_data.
  - The same edge clears pending[write_reg].
- Issue:
  - On the edge, if issue_valid, not busy, and not (ZERO_REG and issue_reg=0): pending[issue_reg] <= 1.
- Simultaneous issue and writeback to the same index:
  - Data is written and the pending bit ends at 1 (the new producer wins).
  - pending_count stays unchanged for that index.
- Writeback to a non-pending register: data is written, and pending stays 0 with no underflow of pending_count.
- Issue to an already-pending register: pending stays 1 with no double count.
- pendingN:
  - Equals pending[read_regN] registered state.
  - If BYPASS, a same-cycle legal writeback to read_regN forces pendingN=0, unless a same-cycle issue targets the same index.
  - pendingN is 0 for index 0 when ZERO_REG.
- pending_count:
  - Registered; equals the popcount of pending bits after each edge.
  - Range 0..DEPTH.
- Index arithmetic is unsigned; there are no out-of-range indices by construction.

Test Plan:
- Reset for 2 cycles, then release → init_busy=1 for exactly 32 edges (default params) and drops on the 32nd; afterwards read_reg1=7 gives 0. reg_write of $7=0xDEADBEEF during busy → $7 still reads 0 after busy ends.
- Write $5=0x12345678, with read_reg1=5 in the same cycle → with BYPASS=1, read_data1=0x12345678 in that cycle; with BYPASS=0, it shows the old value and the new value the next cycle.
- Write $0=0xFFFFFFFF and issue to $0 → read_data1=0, pending1=0, pending_count=0.
- Issue $3, then issue $4 → pending_count=2. Writeback $3=0xA → pending1 (read_reg1=3) is 0 that cycle (BYPASS=1), and pending_count=1 after the edge.
- Same-cycle issue $9 and writeback $9=0x55 → afterwards $9 reads 0x55, pending1 (read_reg1=9)=1, pending_count unchanged.
- Assert reset at sweep entry 10 for 1 cycle, holding $9 pending → pending_count=0; sweep restarts and init_busy stays high for a further 32 edges.
